control_unit: RTL and testbench
===============================

Name: control_unit

Overview:
- Microprogram sequencer: the initiator that drives the ALU's control strobes (add, sub, write, read) and the memory, PC, AR and IR strobes of the MachineV datapath.
- Fetches, decodes and executes one instruction at a time from an external IR opcode field.
- Sits between the IR/flag outputs of the datapath and every control input on the shared 8-bit data bus.

Parameters:
- OP_W, 3, opcode width (IR[7:5]).
- CNT_W, 16, width of the retired-instruction counter.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous reset, active-high.
- run  in  1  1 = free-run; 0 = stop at the next instruction boundary.
- ir_op  in  OP_W  opcode field from IR.
- acc_n  in  1  Acc[7] (negative flag).
- acc_z  in  1  Acc==0 (zero flag).
- alu_add  out  1  ALU add (with alu_write: Acc<=Acc+Dbus).
- alu_sub  out  1  ALU subtract (with alu_write: Acc<=Acc-Dbus).
- alu_write  out  1  ALU loads from Dbus.
- alu_read  out  1  ALU drives Acc onto Dbus.
- mem_read  out  1  memory drives Dbus from [AR].
- mem_write  out  1  memory stores Dbus at [AR].
- ir_write  out  1  IR loads from Dbus.
- ir_addr_out  out  1  IR address field drives address bus.
- pc_out  out  1  PC drives address bus.
- pc_inc  out  1  PC<=PC+1.
- pc_write  out  1  PC loads from address bus.
- ar_write  out  1  AR loads from address bus.
- halted  out  1  1 after STP.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- Reset (RST=1 at a rising edge): state<=S_NEXT, instr_count<=0, halted<=0. Reset wins over every other event, including mid-instruction and from S_HALT.
- Control outputs are Moore decodes of the state and the opcode latched at S_FETCH exit. Exactly the listed strobes are 1 in each state; all others are 0.
- Opcodes: 0 STP, 1 DOD, 2 ODE, 3 POB, 4 LAD, 5 SOB, 6 SOM, 7 SOZ/NOP.
- S_NEXT: pc_out, ar_write.
  - Goes to S_FETCH when run=1 and halted=0.
  - Otherwise holds; the repeated strobes are idempotent.
- S_FETCH: mem_read, ir_write, pc_inc. Goes to S_ADDR for DOD/ODE/POB/LAD; otherwise to S_EXEC.
- S_ADDR: ir_addr_out, ar_write. Goes to S_EXEC.
- S_EXEC strobes, per opcode:
  - DOD: mem_read, alu_add, alu_write.
  - ODE: mem_read, alu_sub, alu_write.
  - POB: mem_read, alu_write.
  - LAD: alu_read, mem_write.
  - SOB: ir_addr_out, pc_write.
  - SOM: ir_addr_out, pc_write only if acc_n=1 (sampled in S_EXEC).
  - 7: see Optional Feature.
  - STP: no strobes.
- S_EXEC transitions: goes to S_NEXT, or to S_HALT for STP. instr_count increments on S_EXEC exit and wraps modulo 2^CNT_W.
- S_HALT: halted=1, no strobes. Leaves only by reset.
- Invariants, never both 1 in any state:
  - alu_read and mem_read.
  - alu_add and alu_sub.
  - pc_out and ir_addr_out.
- Latency per instruction:
  - DOD/ODE/POB/LAD: 4 cycles.
  - SOB/SOM/SOZ/NOP: 3 cycles.
- run is sampled only in S_NEXT. Dropping run mid-instruction completes that instruction first.

Optional Feature:
- Macro: CU_SOZ_EN.
- Defined: opcode 7 = SOZ. In S_EXEC it asserts ir_addr_out and pc_write iff acc_z=1.
- Undefined: opcode 7 = NOP. No S_EXEC strobes; instr_count still increments.

Decomposition:
- Package machinev_pkg:
  - opcode constants (OP_STP..OP_SOZ);
  - state enum (S_NEXT, S_FETCH, S_ADDR, S_EXEC, S_HALT);
  - control-word struct bundling the 13 strobes.
- Sub-module cu_decode: combinational (state, opcode, acc_n, acc_z) -> control word.
- control_unit keeps the FSM, opcode latch, halted and counter.

Test Plan:
- RST=1 for 2 cycles, then run=1 with ir_op=3 (POB): cycle 1 pc_out+ar_write; cycle 2 mem_read+ir_write+pc_inc; cycle 3 ir_addr_out+ar_write; cycle 4 mem_read+alu_write. instr_count=1.
- ir_op=1 then ir_op=2: S_EXEC shows alu_add+alu_write, then alu_sub+alu_write. alu_add and alu_sub are never both 1.
- ir_op=6: with acc_n=1, pc_write=1 in S_EXEC; with acc_n=0, pc_write=0. Both take 3 cycles.
- ir_op=7, acc_z=1: pc_write=1 with CU_SOZ_EN defined; 0 without. instr_count increments either way.
- ir_op=0: halted=1 after 3 cycles, all strobes 0 for 10 more cycles, then RST=1 restores S_NEXT and halted=0.
- run=0 held during a LAD: LAD completes (alu_read+mem_write seen), FSM parks in S_NEXT; run=1 resumes the next fetch one cycle later.
- Preload instr_count to 0xFFFF via 65535 NOPs: the next retire wraps it to 0.

Source files
------------

// File: rtl/machinev_pkg.sv
// MachineV control-unit shared types: opcodes, sequencer states, control word.
package machinev_pkg;

  localparam logic [2:0] OP_STP = 3'd0;
  localparam logic [2:0] OP_DOD = 3'd1;
  localparam logic [2:0] OP_ODE = 3'd2;
  localparam logic [2:0] OP_POB = 3'd3;
  localparam logic [2:0] OP_LAD = 3'd4;
  localparam logic [2:0] OP_SOB = 3'd5;
  localparam logic [2:0] OP_SOM = 3'd6;
  localparam logic [2:0] OP_SOZ = 3'd7;

  typedef enum logic [2:0] {
    S_NEXT,
    S_FETCH,
    S_ADDR,
    S_EXEC,
    S_HALT
  } state_t;

  typedef struct packed {
    logic alu_add;
    logic alu_sub;
    logic alu_write;
    logic alu_read;
    logic mem_read;
    logic mem_write;
    logic ir_write;
    logic ir_addr_out;
    logic pc_out;
    logic pc_inc;
    logic pc_write;
    logic ar_write;
    logic halted;
  } ctrl_t;

  // Memory-operand instructions take an extra address-load cycle.
  function automatic logic needs_addr(input logic [2:0] op);
    return (op == OP_DOD) || (op == OP_ODE) ||
           (op == OP_POB) || (op == OP_LAD);
  endfunction

endpackage

// File: rtl/control_unit_decode.sv
// Moore strobe decode for the MachineV sequencer.
// CU_SOZ_EN: opcode 7 becomes SOZ (branch on zero) instead of NOP.
module cu_decode
  import machinev_pkg::*;
(
  input  state_t     i_state,
  input  logic [2:0] i_op,
  input  logic       i_acc_n,
  input  logic       i_acc_z,
  output ctrl_t      o_cw
);

`ifndef CU_SOZ_EN
  logic w_unused_acc_z;
  assign w_unused_acc_z = i_acc_z;
`endif

  always_comb begin
    o_cw = '0;
    unique case (i_state)
      S_NEXT: begin
        o_cw.pc_out   = 1'b1;
        o_cw.ar_write = 1'b1;
      end
      S_FETCH: begin
        o_cw.mem_read = 1'b1;
        o_cw.ir_write = 1'b1;
        o_cw.pc_inc   = 1'b1;
      end
      S_ADDR: begin
        o_cw.ir_addr_out = 1'b1;
        o_cw.ar_write    = 1'b1;
      end
      S_EXEC: begin
        unique case (i_op)
          OP_DOD: begin
            o_cw.mem_read  = 1'b1;
            o_cw.alu_add   = 1'b1;
            o_cw.alu_write = 1'b1;
          end
          OP_ODE: begin
            o_cw.mem_read  = 1'b1;
            o_cw.alu_sub   = 1'b1;
            o_cw.alu_write = 1'b1;
          end
          OP_POB: begin
            o_cw.mem_read  = 1'b1;
            o_cw.alu_write = 1'b1;
          end
          OP_LAD: begin
            o_cw.alu_read  = 1'b1;
            o_cw.mem_write = 1'b1;
          end
          OP_SOB: begin
            o_cw.ir_addr_out = 1'b1;
            o_cw.pc_write    = 1'b1;
          end
          OP_SOM: begin
            o_cw.ir_addr_out = i_acc_n;
            o_cw.pc_write    = i_acc_n;
          end
          OP_SOZ: begin
`ifdef CU_SOZ_EN
            o_cw.ir_addr_out = i_acc_z;
            o_cw.pc_write    = i_acc_z;
`endif
          end
          default: ;
        endcase
      end
      S_HALT: o_cw.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// MachineV microprogram sequencer: FSM, opcode latch, retire counter.
// CU_SOZ_EN selects SOZ for opcode 7 (see cu_decode).
module control_unit
  import machinev_pkg::*;
#(
  parameter int OP_W  = 3,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             run,
  input  logic [OP_W-1:0]  ir_op,
  input  logic             acc_n,
  input  logic             acc_z,
  output logic             alu_add,
  output logic             alu_sub,
  output logic             alu_write,
  output logic             alu_read,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             ir_addr_out,
  output logic             pc_out,
  output logic             pc_inc,
  output logic             pc_write,
  output logic             ar_write,
  output logic             halted,
  output logic [CNT_W-1:0] instr_count
);

  state_t           r_state;
  logic [OP_W-1:0]  r_op;
  logic [CNT_W-1:0] r_cnt;
  ctrl_t            w_cw;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_NEXT;
      r_op    <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_NEXT:
          if (run && !w_cw.halted) r_state <= S_FETCH;
        S_FETCH: begin
          r_op    <= ir_op;
          r_state <= needs_addr(ir_op) ? S_ADDR : S_EXEC;
        end
        S_ADDR: r_state <= S_EXEC;
        S_EXEC: begin
          r_cnt   <= r_cnt + CNT_W'(1);
          r_state <= (r_op == OP_STP) ? S_HALT : S_NEXT;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_NEXT;
      endcase
    end
  end

  cu_decode u_dec (
    .i_state (r_state),
    .i_op    (r_op),
    .i_acc_n (acc_n),
    .i_acc_z (acc_z),
    .o_cw    (w_cw)
  );

  assign alu_add     = w_cw.alu_add;
  assign alu_sub     = w_cw.alu_sub;
  assign alu_write   = w_cw.alu_write;
  assign alu_read    = w_cw.alu_read;
  assign mem_read    = w_cw.mem_read;
  assign mem_write   = w_cw.mem_write;
  assign ir_write    = w_cw.ir_write;
  assign ir_addr_out = w_cw.ir_addr_out;
  assign pc_out      = w_cw.pc_out;
  assign pc_inc      = w_cw.pc_inc;
  assign pc_write    = w_cw.pc_write;
  assign ar_write    = w_cw.ar_write;
  assign halted      = w_cw.halted;
  assign instr_count = r_cnt;

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit with an instruction-level reference model.
module tb_control_unit;

  localparam int CW = 8;

  logic CLK = 1'b0;
  logic RST, run, acc_n, acc_z;
  logic [2:0] ir_op;
  logic alu_add, alu_sub, alu_write, alu_read;
  logic mem_read, mem_write, ir_write, ir_addr_out;
  logic pc_out, pc_inc, pc_write, ar_write, halted;
  logic [CW-1:0] instr_count;

  int checks = 0;
  int failures = 0;
  int hc = 0;

  always #5 CLK = ~CLK;

  control_unit #(.OP_W(3), .CNT_W(CW)) dut (
    .CLK(CLK), .RST(RST), .run(run), .ir_op(ir_op),
    .acc_n(acc_n), .acc_z(acc_z),
    .alu_add(alu_add), .alu_sub(alu_sub),
    .alu_write(alu_write), .alu_read(alu_read),
    .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .ir_addr_out(ir_addr_out),
    .pc_out(pc_out), .pc_inc(pc_inc),
    .pc_write(pc_write), .ar_write(ar_write),
    .halted(halted), .instr_count(instr_count)
  );

  localparam logic [12:0] ARW = 13'h0001;
  localparam logic [12:0] PCW = 13'h0002;
  localparam logic [12:0] PCI = 13'h0004;
  localparam logic [12:0] PCO = 13'h0008;
  localparam logic [12:0] IAO = 13'h0010;
  localparam logic [12:0] IRW = 13'h0020;
  localparam logic [12:0] MW  = 13'h0040;
  localparam logic [12:0] MR  = 13'h0080;
  localparam logic [12:0] AR  = 13'h0100;
  localparam logic [12:0] AW  = 13'h0200;
  localparam logic [12:0] SUB = 13'h0400;
  localparam logic [12:0] ADD = 13'h0800;
  localparam logic [12:0] HLT = 13'h1000;

  localparam logic [12:0] W_NEXT  = PCO | ARW;
  localparam logic [12:0] W_FETCH = MR | IRW | PCI;
  localparam logic [12:0] W_ADDR  = IAO | ARW;
`ifdef CU_SOZ_EN
  localparam logic [12:0] SOZ_LIT = IAO | PCW;
`else
  localparam logic [12:0] SOZ_LIT = 13'h0;
`endif

  function automatic logic [12:0] dut_word();
    return {halted, alu_add, alu_sub, alu_write, alu_read,
            mem_read, mem_write, ir_write, ir_addr_out,
            pc_out, pc_inc, pc_write, ar_write};
  endfunction

  // What an instruction does in its execute cycle.
  function automatic logic [12:0] exec_effect(
    input logic [2:0] op, input logic n, input logic z);
    case (op)
      3'd1: return MR | ADD | AW;
      3'd2: return MR | SUB | AW;
      3'd3: return MR | AW;
      3'd4: return AR | MW;
      3'd5: return IAO | PCW;
      3'd6: return n ? (IAO | PCW) : 13'h0;
`ifdef CU_SOZ_EN
      3'd7: return z ? (IAO | PCW) : 13'h0;
`endif
      default: return 13'h0;
    endcase
  endfunction

  // Model: position k within the current instruction's cycle list.
  int          m_k = 0;
  int          m_len = 3;
  bit          m_halt = 0;
  bit          m_live = 0;
  logic [2:0]  m_op = 3'd0;
  int unsigned m_cnt = 0;

  always @(posedge CLK) begin
    m_live <= 1'b1;
    if (RST) begin
      m_k <= 0;
      m_halt <= 1'b0;
      m_cnt <= 0;
    end else if (!m_halt) begin
      if (m_k == 0) begin
        if (run) m_k <= 1;
      end else if (m_k == 1) begin
        m_op  <= ir_op;
        m_len <= (ir_op >= 3'd1 && ir_op <= 3'd4) ? 4 : 3;
        m_k   <= 2;
      end else if (m_k == m_len - 1) begin
        m_cnt <= (m_cnt + 1) % (1 << CW);
        if (m_op == 3'd0) m_halt <= 1'b1;
        m_k <= 0;
      end else begin
        m_k <= m_k + 1;
      end
    end
  end

  function automatic logic [12:0] model_word();
    if (m_halt) return HLT;
    if (m_k == 0) return W_NEXT;
    if (m_k == 1) return W_FETCH;
    if (m_k < m_len - 1) return W_ADDR;
    return exec_effect(m_op, acc_n, acc_z);
  endfunction

  always @(negedge CLK) begin
    if (m_live) begin
      checks++;
      if (dut_word() !== model_word()) begin
        failures++;
        $display("FAIL cycle_strobes t=%0t got %h want %h",
                 $time, dut_word(), model_word());
      end
      checks++;
      if (instr_count !== CW'(m_cnt)) begin
        failures++;
        $display("FAIL cycle_count t=%0t got %0d want %0d",
                 $time, instr_count, m_cnt);
      end
      checks++;
      if ((alu_read & mem_read) || (alu_add & alu_sub) ||
          (pc_out & ir_addr_out)) begin
        failures++;
        $display("FAIL invariant t=%0t got %h want no conflict",
                 $time, dut_word());
      end
    end
  end

  task automatic chk(input string nm, input logic [12:0] got,
                     input logic [12:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got %h want %h", nm, got, want);
    end
  endtask

  task automatic chk_cnt(input string nm, input int want);
    checks++;
    if (instr_count !== CW'(want)) begin
      failures++;
      $display("FAIL %s got %0d want %0d", nm, instr_count, want);
    end
  endtask

  // Called at the negedge of an S_NEXT cycle; returns at the next one.
  task automatic do_instr(input logic [2:0] op, input logic n,
                          input logic z, input int len,
                          input logic [12:0] lit, input string nm);
    #1;
    ir_op = op;
    acc_n = n;
    acc_z = z;
    repeat (len - 1) @(negedge CLK);
    chk(nm, dut_word(), lit);
    @(negedge CLK);
    hc++;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; run = 1'b0; ir_op = 3'd0; acc_n = 1'b0; acc_z = 1'b0;
    repeat (2) @(negedge CLK);
    chk("reset_word", dut_word(), W_NEXT);
    chk_cnt("reset_count", 0);

    #1; RST = 1'b0; run = 1'b1; ir_op = 3'd3;
    @(negedge CLK); chk("pob_fetch", dut_word(), W_FETCH);
    @(negedge CLK); chk("pob_addr", dut_word(), W_ADDR);
    @(negedge CLK); chk("pob_exec", dut_word(), MR | AW);
    @(negedge CLK); chk("pob_next", dut_word(), W_NEXT);
    hc++;
    chk_cnt("pob_count", hc);

    do_instr(3'd1, 1'b0, 1'b0, 4, MR | ADD | AW, "dod_exec");
    do_instr(3'd2, 1'b0, 1'b0, 4, MR | SUB | AW, "ode_exec");
    do_instr(3'd6, 1'b1, 1'b0, 3, IAO | PCW, "som_taken");
    do_instr(3'd6, 1'b0, 1'b0, 3, 13'h0, "som_not_taken");
    do_instr(3'd5, 1'b0, 1'b0, 3, IAO | PCW, "sob_exec");
    do_instr(3'd7, 1'b0, 1'b1, 3, SOZ_LIT, "op7_exec");
    chk_cnt("count_after_7", 7);

    #1; ir_op = 3'd4; acc_z = 1'b0;
    @(negedge CLK);
    #1; run = 1'b0;
    @(negedge CLK);
    @(negedge CLK); chk("lad_exec", dut_word(), AR | MW);
    @(negedge CLK);
    @(negedge CLK); chk("parked", dut_word(), W_NEXT);
    hc++;
    chk_cnt("lad_count", 8);
    #1; run = 1'b1; ir_op = 3'd7;
    @(negedge CLK); chk("resume_fetch", dut_word(), W_FETCH);
    @(negedge CLK);
    @(negedge CLK);
    hc++;

    while (hc < 255) do_instr(3'd7, 1'b0, 1'b0, 3, 13'h0, "nop_exec");
    chk_cnt("count_max", 255);
    do_instr(3'd7, 1'b0, 1'b0, 3, 13'h0, "nop_exec");
    chk_cnt("count_wrap", 0);

    #1; ir_op = 3'd0;
    @(negedge CLK);
    @(negedge CLK); chk("stp_exec", dut_word(), 13'h0);
    @(negedge CLK); chk("halted", dut_word(), HLT);
    chk_cnt("stp_count", 1);
    repeat (10) begin
      @(negedge CLK);
      chk("halt_hold", dut_word(), HLT);
    end
    #1; RST = 1'b1;
    @(negedge CLK); chk("halt_reset", dut_word(), W_NEXT);
    chk_cnt("halt_reset_count", 0);
    #1; RST = 1'b0; run = 1'b0;
    @(negedge CLK); chk("idle_next", dut_word(), W_NEXT);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
